// File: rtl/alu_pkg.sv
// Shared opcode encodings, legality check and sequencer state type for the 4-bit ALU front end.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Every opcode with the top bit set is illegal.
   function automatic logic is_legal_op(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Registers one ALU request, drives the ALU for a full cycle, returns result plus selected carry.
// Latency: response valid 2 cycles after the request cycle (legal), 1 cycle (illegal).
// Backpressure: one op in flight; req_ready low until the response handshake completes.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int OPW   = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_c,
   input  logic [OPW-1:0]   req_opcode,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_c,
   output logic [OPW-1:0]   alu_opcode,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carrysum,
   input  logic             alu_carrysub,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_err,
   output logic [CNT_W-1:0] op_count
);

   state_t state, state_nxt;
   logic   accept;
   logic   req_legal;
   logic   capture;
   logic   rsp_hs;
   logic   carry_sel;

   assign req_legal = is_legal_op(req_opcode);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      rsp_hs    = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = req_legal ? ISSUE : RESP;
            end
         end
         ISSUE: begin
            capture   = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               rsp_hs    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Carry is chosen from the issued opcode, not whatever sits on req_opcode now.
   always_comb begin
      carry_sel = 1'b0;
      if (alu_opcode == OP_ADD) begin
         carry_sel = alu_carrysum;
      end else if (alu_opcode == OP_SUB) begin
         carry_sel = alu_carrysub;
      end
   end

   // Illegal requests leave the ALU drive registers untouched.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_c      <= 1'b0;
         alu_opcode <= '0;
      end else if (accept && req_legal) begin
         alu_a      <= req_a;
         alu_b      <= req_b;
         alu_c      <= req_c;
         alu_opcode <= req_opcode;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_err    <= 1'b0;
      end else if (accept) begin
         rsp_err <= !req_legal;
         if (!req_legal) begin
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
         end
      end else if (capture) begin
         rsp_result <= alu_result;
         rsp_carry  <= carry_sel;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_count <= '0;
      end else if (rsp_hs && !rsp_err) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: directed requests push expected responses, a negedge monitor pops them on each response handshake.
module tb_alu_op_sequencer;

   logic       clk;
   logic       reset_n;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_a;
   logic [3:0] req_b;
   logic       req_c;
   logic [2:0] req_opcode;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic       alu_c;
   logic [2:0] alu_opcode;
   logic [3:0] alu_result;
   logic       alu_carrysum;
   logic       alu_carrysub;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_result;
   logic       rsp_carry;
   logic       rsp_err;
   logic [7:0] op_count;

   int n_cmp = 0;
   int n_err = 0;
   int n_push = 0;
   int n_pop = 0;

   // {err, carry, result}
   logic [5:0] exp_q[$];

   alu_op_sequencer #(.WIDTH(4), .OPW(3), .CNT_W(8)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_c        (req_c),
      .req_opcode   (req_opcode),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_c        (alu_c),
      .alu_opcode   (alu_opcode),
      .alu_result   (alu_result),
      .alu_carrysum (alu_carrysum),
      .alu_carrysub (alu_carrysub),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_carry    (rsp_carry),
      .rsp_err      (rsp_err),
      .op_count     (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU stand-in: both carries always computed, result selected by opcode.
   logic [4:0] alu_sum;
   logic [4:0] alu_dif;
   always_comb begin
      alu_sum      = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_c};
      alu_dif      = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0, alu_c};
      alu_carrysum = alu_sum[4];
      alu_carrysub = alu_dif[4];
      case (alu_opcode)
         3'b000:  alu_result = alu_sum[3:0];
         3'b001:  alu_result = alu_dif[3:0];
         3'b010:  alu_result = alu_a & alu_b;
         3'b011:  alu_result = alu_a | alu_b;
         default: alu_result = 4'h0;
      endcase
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic logic [5:0] ref_rsp(input logic [3:0] a, input logic [3:0] b,
                                          input logic c, input logic [1:0] op);
      logic [4:0] t;
      case (op)
         2'd0: begin t = a + b + c; return {1'b0, t[4], t[3:0]}; end
         2'd1: begin t = {1'b0, a} - {1'b0, b} - {4'b0, c}; return {1'b0, t[4], t[3:0]}; end
         2'd2: return {2'b00, a & b};
         default: return {2'b00, a | b};
      endcase
   endfunction

   always @(negedge clk) begin
      if (reset_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_rsp: got result 0x%0h err %0b, expected no response", rsp_result, rsp_err);
         end else begin
            logic [5:0] e;
            e = exp_q.pop_front();
            n_pop++;
            chk("rsp_result", rsp_result, e[3:0]);
            chk("rsp_carry", rsp_carry, e[4]);
            chk("rsp_err", rsp_err, e[5]);
         end
      end
   end

   // Returns #1 after the accept edge with req_valid dropped.
   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [2:0] op, input logic [5:0] expv);
      bit done;
      done = 0;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (req_ready) begin
            req_a      = a;
            req_b      = b;
            req_c      = c;
            req_opcode = op;
            req_valid  = 1'b1;
            @(posedge clk);
            exp_q.push_back(expv);
            n_push++;
            #1;
            req_valid = 1'b0;
            done = 1;
         end
      end
      if (!done) chk("send_timeout", 1, 0);
   endtask

   task automatic wait_idle();
      bit done;
      done = 0;
      for (int k = 0; k < 30 && !done; k++) begin
         if (req_ready && !rsp_valid) done = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!done) chk("idle_timeout", 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

   initial begin
      int seen;
      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_a      = 4'h0;
      req_b      = 4'h0;
      req_c      = 1'b0;
      req_opcode = 3'b000;
      rsp_ready  = 1'b1;
      #12;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_alu_opcode", alu_opcode, 0);
      chk("rst_rsp_result", rsp_result, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1);

      // 1: add 9+8 -> 1, carry out
      send(4'h9, 4'h8, 1'b0, 3'b000, {1'b0, 1'b1, 4'h1});
      chk("t1_lat_edge1", rsp_valid, 0);
      @(posedge clk);
      #1;
      chk("t1_lat_edge2", rsp_valid, 1);
      wait_idle();
      chk("t1_op_count", op_count, 1);

      // 2: and / or
      send(4'hC, 4'hA, 1'b0, 3'b010, {1'b0, 1'b0, 4'h8});
      wait_idle();
      send(4'hC, 4'hA, 1'b1, 3'b011, {1'b0, 1'b0, 4'hE});
      wait_idle();
      chk("t2_op_count", op_count, 3);

      // 3: illegal opcode
      send(4'h7, 4'h7, 1'b1, 3'b101, {1'b1, 1'b0, 4'h0});
      chk("t3_lat_edge1", rsp_valid, 1);
      chk("t3_alu_opcode", alu_opcode, 3'b011);
      wait_idle();
      chk("t3_op_count", op_count, 3);
      chk("t3_alu_opcode_after", alu_opcode, 3'b011);

      // 4: sub 3-5 with response stalled; a junk request is held meanwhile
      rsp_ready = 1'b0;
      send(4'h3, 4'h5, 1'b0, 3'b001, {1'b0, 1'b1, 4'hE});
      req_valid  = 1'b1;
      req_opcode = 3'b000;
      req_a      = 4'hF;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_rsp_valid", rsp_valid, 1);
         chk("t4_rsp_result", rsp_result, 4'hE);
         chk("t4_rsp_carry", rsp_carry, 1);
         chk("t4_req_ready", req_ready, 0);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_req_ready_after", req_ready, 1);
      chk("t4_op_count", op_count, 4);

      // 5: reset during ISSUE
      send(4'h2, 4'h3, 1'b0, 3'b000, {1'b0, 1'b0, 4'h5});
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      n_push = 0;
      n_pop = 0;
      chk("t5_rsp_valid", rsp_valid, 0);
      chk("t5_op_count", op_count, 0);
      chk("t5_alu_a", alu_a, 0);
      chk("t5_alu_b", alu_b, 0);
      chk("t5_alu_opcode", alu_opcode, 0);
      chk("t5_rsp_result", rsp_result, 0);
      chk("t5_rsp_carry", rsp_carry, 0);
      chk("t5_rsp_err", rsp_err, 0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("t5_no_rsp", seen, 0);
      chk("t5_req_ready", req_ready, 1);
      chk("t5_op_count_after", op_count, 0);

      // 6: 256 back-to-back legal ops, counter wraps
      for (int i = 0; i < 256; i++) begin
         logic [3:0] a, b;
         logic       c;
         logic [1:0] op;
         a  = i[3:0];
         b  = i[7:4] ^ 4'h6;
         c  = i[2] ^ i[5];
         op = i[1:0] ^ i[3:2];
         send(a, b, c, {1'b0, op}, ref_rsp(a, b, c, op));
         if (i == 254) begin
            wait_idle();
            chk("t6_op_count_255", op_count, 255);
         end
      end
      wait_idle();
      chk("t6_op_count_wrap", op_count, 0);
      chk("t6_rsp_count", n_pop, n_push);
      chk("t6_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
